brew_unit_scheduler: RTL and testbench

- Shares one brewing unit (water, coffee, cream and sugar valves) between N_PANEL customer front panels.
- Each panel is a coin/selection controller that has already validated payment.
- The block arbitrates pending orders round-robin, latches the granted menu and sequences the valve phases with per-phase cycle counters.
- It reports completion or abort back to the owning panel.

---
 rtl/brew_pkg.sv | 35 +++
 rtl/brew_unit_scheduler_rr_arbiter.sv | 65 ++++++
 rtl/brew_unit_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_brew_unit_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brew_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brew_pkg
//  Description : Shared types and menu encodings for the brewing-unit
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package brew_pkg;

    // Brew sequencer states; DONE is a single-cycle completion state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WATER  = 3'd1,
        ST_COFFEE = 3'd2,
        ST_CREAM  = 3'd3,
        ST_SUGAR  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Per-panel menu selection codes.
    localparam logic [1:0] MENU_NONE        = 2'b00;
    localparam logic [1:0] MENU_BLACK       = 2'b01;
    localparam logic [1:0] MENU_CREAM       = 2'b10;
    localparam logic [1:0] MENU_CREAM_SUGAR = 2'b11;

    // Width of the per-phase cycle counter.
    localparam int CNT_W = 16;

    // True when the selected drink needs the cream phase.
    function automatic logic menu_has_cream(input logic [1:0] m);
        return (m == MENU_CREAM) || (m == MENU_CREAM_SUGAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/brew_unit_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The grant is combinational from the
//                request vector and the priority pointer; the pointer moves
//                past the granted requester when advance is strobed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Pick the first requester at or above the pointer, else wrap around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr_q))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
            end
        end
    end

    // Next pointer is one past the winner, modulo N.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/brew_unit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : brew_unit_scheduler
//  Description : Shares one brewing unit between N_PANEL front panels.
//                Arbitrates orders round-robin, latches the granted menu and
//                sequences the Water/Coffee/Cream/Sugar valve phases.
//                Optional macro BREW_CUP_COUNT_EN adds a saturating
//                Cup_Count output counting finished drinks.
//  Revision    : 1.0 - initial release
// ============================================================================
module brew_unit_scheduler
    import brew_pkg::*;
#(
    parameter int N_PANEL    = 2,
    parameter int WATER_CYC  = 4,
    parameter int COFFEE_CYC = 2,
    parameter int CREAM_CYC  = 1,
    parameter int SUGAR_CYC  = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N_PANEL-1:0]   Req,
    input  logic [2*N_PANEL-1:0] Menu,
    input  logic                 Abort,
    output logic [N_PANEL-1:0]   Grant,
    output logic [N_PANEL-1:0]   Done,
    output logic [N_PANEL-1:0]   Aborted,
    output logic                 Water,
    output logic                 Coffee,
    output logic                 Cream,
    output logic                 Sugar,
`ifdef BREW_CUP_COUNT_EN
    output logic [7:0]           Cup_Count,
`endif
    output logic                 Busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         menu_q, menu_d;
    logic [N_PANEL-1:0] owner_q, owner_d;
    logic [N_PANEL-1:0] grant_q, grant_d;
    logic [N_PANEL-1:0] aborted_q, aborted_d;

    logic [N_PANEL-1:0] cand;
    logic [N_PANEL-1:0] arb_grant;
    logic [1:0]         menu_sel;
    logic               advance;

    // Only panels with a real selection compete; pick the winner's menu.
    always_comb begin
        cand     = '0;
        menu_sel = MENU_NONE;
        for (int i = 0; i < N_PANEL; i++) begin
            cand[i] = Req[i] && (Menu[2*i +: 2] != MENU_NONE);
            if (arb_grant[i]) begin
                menu_sel = Menu[2*i +: 2];
            end
        end
    end

    rr_arbiter #(
        .N (N_PANEL)
    ) u_arb (
        .clk     (Clock),
        .rst     (Reset),
        .req     (cand),
        .advance (advance),
        .grant   (arb_grant)
    );

    // Next-state, phase counter and latch logic; abort overrides any phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        menu_d    = menu_q;
        owner_d   = owner_q;
        grant_d   = '0;
        aborted_d = '0;
        advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!Abort && (|cand)) begin
                    advance = 1'b1;
                    state_d = ST_WATER;
                    cnt_d   = CNT_W'(WATER_CYC - 1);
                    menu_d  = menu_sel;
                    owner_d = arb_grant;
                    grant_d = arb_grant;
                end
            end
            ST_WATER: begin
                if (cnt_q == '0) begin
                    state_d = ST_COFFEE;
                    cnt_d   = CNT_W'(COFFEE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_COFFEE: begin
                if (cnt_q == '0) begin
                    if (menu_has_cream(menu_q)) begin
                        state_d = ST_CREAM;
                        cnt_d   = CNT_W'(CREAM_CYC - 1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CREAM: begin
                if (cnt_q == '0) begin
                    if (menu_q == MENU_CREAM_SUGAR) begin
                        state_d = ST_SUGAR;
                        cnt_d   = CNT_W'(SUGAR_CYC - 1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SUGAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A valve phase abandoned by Abort reports back to its owner only.
        if (Abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            aborted_d = owner_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            menu_q    <= MENU_NONE;
            owner_q   <= '0;
            grant_q   <= '0;
            aborted_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            menu_q    <= menu_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            aborted_q <= aborted_d;
        end
    end

    // Moore valve outputs and status pulses.
    always_comb begin
        Water   = (state_q == ST_WATER);
        Coffee  = (state_q == ST_COFFEE);
        Cream   = (state_q == ST_CREAM);
        Sugar   = (state_q == ST_SUGAR);
        Busy    = (state_q != ST_IDLE);
        Done    = (state_q == ST_DONE) ? owner_q : '0;
        Grant   = grant_q;
        Aborted = aborted_q;
    end

`ifdef BREW_CUP_COUNT_EN
    logic [7:0] cup_q, cup_d;

    // Count finished drinks, holding at the top of the range.
    always_comb begin
        cup_d = cup_q;
        if ((state_q == ST_DONE) && (cup_q != 8'hFF)) begin
            cup_d = cup_q + 8'd1;
        end
    end

    // Cup counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cup_q <= '0;
        end else begin
            cup_q <= cup_d;
        end
    end

    assign Cup_Count = cup_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brew_unit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brew_unit_scheduler
//  Description : Self-checking bench for brew_unit_scheduler (defaults,
//                N_PANEL=2). Per-cycle vector table plus hand sequences for
//                alternation, abort, abort-in-idle and mid-brew reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brew_unit_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] menu;
    logic       abort;
    logic [1:0] grant, done, aborted;
    logic       water, coffee, cream, sugar, busy;
`ifdef BREW_CUP_COUNT_EN
    logic [7:0] cup_count;
`endif

    int checks = 0;
    int errors = 0;

    brew_unit_scheduler #(
        .N_PANEL    (2),
        .WATER_CYC  (4),
        .COFFEE_CYC (2),
        .CREAM_CYC  (1),
        .SUGAR_CYC  (1)
    ) dut (
        .Clock   (clk),
        .Reset   (rst),
        .Req     (req),
        .Menu    (menu),
        .Abort   (abort),
        .Grant   (grant),
        .Done    (done),
        .Aborted (aborted),
        .Water   (water),
        .Coffee  (coffee),
        .Cream   (cream),
        .Sugar   (sugar),
`ifdef BREW_CUP_COUNT_EN
        .Cup_Count (cup_count),
`endif
        .Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs: {grant, done, aborted, water, coffee, cream, sugar, busy}
    logic [10:0] act;
    assign act = {grant, done, aborted, water, coffee, cream, sugar, busy};

    typedef struct {
        logic [1:0]  req;
        logic [3:0]  menu;
        logic        abort;
        logic [10:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    localparam logic [3:0] V_W  = 4'b1000;
    localparam logic [3:0] V_C  = 4'b0100;
    localparam logic [3:0] V_CR = 4'b0010;
    localparam logic [3:0] V_S  = 4'b0001;
    localparam logic [3:0] V_0  = 4'b0000;

    function automatic logic [10:0] ex(input logic [1:0] g, input logic [1:0] d,
                                       input logic [1:0] a, input logic [3:0] v,
                                       input logic b);
        return {g, d, a, v, b};
    endfunction

    function automatic vec_t mk(input logic [1:0] r, input logic [3:0] m,
                                input logic ab, input logic [10:0] e);
        vec_t v;
        v.req = r; v.menu = m; v.abort = ab; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (g d a valves busy)", name, act, exp);
        end
        checks++;
        if ($countones({water, coffee, cream, sugar}) > 1) begin
            errors++;
            $display("FAIL %s_valves_exclusive: got %b expected at most one set",
                     name, {water, coffee, cream, sugar});
        end
    endtask

    // Drive inputs for one cycle, cross the edge, then compare.
    task automatic apply(input logic [1:0] r, input logic [3:0] m, input logic ab,
                         input logic [10:0] e, input string name);
        req = r; menu = m; abort = ab;
        @(posedge clk); #1;
        check(name, e);
    endtask

    logic [1:0] gseq [4];
    int         ng;
    logic       prev_busy, prev_grant;

    initial begin
        // Scenario 1: panel0 black
        vecs[0]  = mk(2'b01, 4'b0001, 1'b0, ex(2'b01, 2'b00, 2'b00, V_W, 1'b1));
        vecs[1]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[2]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[3]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[4]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[5]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[6]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b01, 2'b00, V_0, 1'b1));
        vecs[7]  = mk(2'b00, 4'b0001, 1'b0, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0));
        // Scenario 2: panel1 cream+sugar; menu changed to black after grant
        vecs[8]  = mk(2'b10, 4'b1100, 1'b0, ex(2'b10, 2'b00, 2'b00, V_W, 1'b1));
        vecs[9]  = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[10] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[11] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[12] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[13] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[14] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_CR, 1'b1));
        vecs[15] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_S, 1'b1));
        vecs[16] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b10, 2'b00, V_0, 1'b1));
        vecs[17] = mk(2'b00, 4'b0100, 1'b0, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0));
        // Scenario 3: panel0 requests with menu 00, panel1 cream
        vecs[18] = mk(2'b11, 4'b1000, 1'b0, ex(2'b10, 2'b00, 2'b00, V_W, 1'b1));
        vecs[19] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[20] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[21] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1));
        vecs[22] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[23] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1));
        vecs[24] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_CR, 1'b1));
        vecs[25] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b10, 2'b00, V_0, 1'b1));
        vecs[26] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0));
        vecs[27] = mk(2'b01, 4'b1000, 1'b0, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0));

        // Reset with requests already present: nothing may move.
        rst = 1'b1; req = 2'b11; menu = 4'b0101; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 11'd0);
`ifdef BREW_CUP_COUNT_EN
        checks++;
        if (cup_count !== 8'd0) begin
            errors++;
            $display("FAIL cup_reset: got %0d expected 0", cup_count);
        end
`endif
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].req, vecs[i].menu, vecs[i].abort, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Both panels request continuously: grants must alternate 0,1,0,1.
        ng = 0;
        prev_busy = busy;
        prev_grant = |grant;
        req = 2'b11; menu = 4'b0101; abort = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            if (grant != 2'b00) begin
                checks++;
                if (($countones(grant) != 1) || prev_busy || prev_grant) begin
                    errors++;
                    $display("FAIL alt_grant_shape: got grant=%b prev_busy=%b prev_grant=%b expected one-hot after idle",
                             grant, prev_busy, prev_grant);
                end
                if (ng < 4) gseq[ng] = grant;
                ng++;
            end
            prev_busy  = busy;
            prev_grant = |grant;
        end
        checks++;
        if (ng != 4) begin
            errors++;
            $display("FAIL alt_count: got %0d expected 4", ng);
        end
        checks++;
        if (gseq[0] !== 2'b01 || gseq[1] !== 2'b10 || gseq[2] !== 2'b01 || gseq[3] !== 2'b10) begin
            errors++;
            $display("FAIL alt_order: got %b %b %b %b expected 01 10 01 10",
                     gseq[0], gseq[1], gseq[2], gseq[3]);
        end

        // Abort in the second COFFEE cycle of panel0's brew; panel1 waiting.
        apply(2'b11, 4'b0101, 1'b0, ex(2'b01, 2'b00, 2'b00, V_W, 1'b1), "ab_grant0");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "ab_w2");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "ab_w3");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "ab_w4");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1), "ab_c1");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1), "ab_c2");
        apply(2'b10, 4'b0101, 1'b1, ex(2'b00, 2'b00, 2'b01, V_0, 1'b0), "ab_pulse");
        apply(2'b10, 4'b0101, 1'b0, ex(2'b10, 2'b00, 2'b00, V_W, 1'b1), "ab_next_grant");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "p1_w2");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "p1_w3");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_W, 1'b1), "p1_w4");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1), "p1_c1");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_C, 1'b1), "p1_c2");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b10, 2'b00, V_0, 1'b1), "p1_done");
        apply(2'b00, 4'b0101, 1'b0, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0), "p1_idle");

        // Abort in IDLE blocks the grant and produces no pulse.
        apply(2'b01, 4'b0101, 1'b1, ex(2'b00, 2'b00, 2'b00, V_0, 1'b0), "idle_abort_block");
        apply(2'b01, 4'b0101, 1'b0, ex(2'b01, 2'b00, 2'b00, V_W, 1'b1), "idle_abort_release");

        // Asynchronous reset mid-WATER, between clock edges.
        req = 2'b00;
        #2 rst = 1'b1;
        #1 check("async_reset", 11'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Pointer was at panel1; reset must return it to panel0.
        apply(2'b11, 4'b0101, 1'b0, ex(2'b01, 2'b00, 2'b00, V_W, 1'b1), "ptr_after_reset");

`ifdef BREW_CUP_COUNT_EN
        // Drive 260 black drinks from panel0 and check saturation.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b01; menu = 4'b0001; abort = 1'b0;
        repeat (260 * 8 + 4) @(posedge clk);
        #1;
        checks++;
        if (cup_count !== 8'd255) begin
            errors++;
            $display("FAIL cup_saturate: got %0d expected 255", cup_count);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
